sample_tick_fifo_sink: RTL and testbench
========================================

Name: sample_tick_fifo_sink

Overview:
- Consumer end of the sample-rate tick: buffers audio samples from the synthesis engine and releases exactly one sample per `tick` toward the DAC/output stage.
- Write side is a valid/ready stream from the voice/mixer pipeline. Read side is paced only by the one-cycle `tick` strobe from the sample-rate tick generator.
- Decouples bursty sample production from the fixed FS output cadence and flags underruns.

Parameters:
- WIDTH, 16, sample width in bits (signed two's complement, passed through untouched).
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock (same domain as the tick generator).
- rst  input  1  reset; synchronous, active-high.
- tick  input  1  sample-rate strobe, one cycle high per sample period.
- in_sample  input  WIDTH  sample from the mixer.
- in_valid  input  1  in_sample is valid.
- in_ready  output  1  FIFO can accept a sample this cycle.
- out_sample  output  WIDTH  registered sample presented to the DAC stage.
- out_valid  output  1  one-cycle strobe: out_sample updated this cycle.
- underrun  output  1  sticky: a tick arrived while the FIFO was empty.
- underrun_clr  input  1  clears underrun.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on posedge clk.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, out_sample=0, out_valid=0, underrun=0.
  - Reset mid-operation discards all buffered samples.
  - Memory contents are don't-care after reset.
- Storage: DEPTH x WIDTH register array. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. A separate count register holds occupancy.
- in_ready: combinational, equal to (count != DEPTH).
- Push: occurs when in_valid && in_ready. mem[wr_ptr] <= in_sample and wr_ptr increments.
- Pop: occurs when tick && count != 0.
  - out_sample <= mem[rd_ptr], rd_ptr increments, out_valid <= 1.
  - Latency: out_sample and out_valid are valid on the cycle after the tick.
- Underrun: tick && count == 0.
  - out_sample holds its previous value (hold-last-sample).
  - out_valid <= 1 still, so the DAC stage keeps its cadence.
  - underrun <= 1.
- No bypass: a push in the same cycle as a tick on an empty FIFO does not satisfy that tick. The tick is an underrun and the pushed sample is stored.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: unchanged.
- Full FIFO plus tick: in_ready is 0 that cycle, so there is no push. The pop frees one slot, and in_ready rises the next cycle.
- out_valid is 0 on every cycle that does not follow a tick.
- underrun_clr clears underrun. If a new underrun event occurs in the same cycle as underrun_clr, the set wins and underrun stays 1.
- level equals count, registered.
- tick high on consecutive cycles: each cycle is treated as an independent pop or underrun; there is no filtering.

Optional Feature:
- Macro: SAMPLE_FIFO_UNDERRUN_COUNT_EN.
- Defined:
  - Adds output underrun_count [15:0], a saturating counter incremented on each underrun event.
  - The counter sticks at 16'hFFFF.
  - It is cleared by rst and by underrun_clr. If clear and an underrun event occur in the same cycle, the result is 1.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst with in_valid=1 and tick=1 -> all outputs 0; level=0, in_ready=1. After release, the first tick gives out_valid=1, out_sample=0, underrun=1.
- Fill and drain (WIDTH=16, DEPTH=8): push 16'h0001..16'h0008 back-to-back -> level=8, in_ready=0, 9th push refused. Then 8 ticks -> out_sample sequence 1..8, each out_valid one cycle after its tick, level ends at 0.
- Underrun hold: push 16'h7FFF, tick, tick -> out_sample 16'h7FFF both times. The second tick sets underrun=1. underrun_clr then clears it.
- Simultaneous: level=3 with push and tick in the same cycle -> level stays 3 and FIFO order is preserved. Empty FIFO with push and tick together -> underrun=1, level=1, and the next tick outputs the pushed sample.
- Wrap-around: 20 push/pop cycles at level 2-3 -> output order matches input order across pointer wrap, with no loss or duplication.
- With SAMPLE_FIFO_UNDERRUN_COUNT_EN defined: 5 ticks on an empty FIFO -> underrun_count=5. underrun_clr concurrent with an underrun tick -> underrun_count=1.

Source files
------------

// File: rtl/sample_tick_fifo_sink.sv
// sample_tick_fifo_sink: buffers audio samples from the synthesis engine and
// releases exactly one sample per sample-rate tick toward the DAC stage.
// A tick on an empty FIFO holds the last sample, still strobes out_valid,
// and sets a sticky underrun flag.
//
// Ports:
//   clk            system clock (same domain as the tick generator)
//   rst            synchronous active-high reset
//   tick           one-cycle sample-rate strobe
//   in_sample      sample from the mixer (WIDTH bits, passed through untouched)
//   in_valid       in_sample is valid
//   in_ready       FIFO can accept a sample this cycle (combinational)
//   out_sample     registered sample presented to the DAC stage
//   out_valid      one-cycle strobe, out_sample updated (cycle after a tick)
//   underrun       sticky flag, a tick found the FIFO empty
//   underrun_clr   clears underrun (a concurrent underrun event wins)
//   level          registered FIFO occupancy, 0..DEPTH
//   underrun_count saturating underrun event counter; present only when
//                  SAMPLE_FIFO_UNDERRUN_COUNT_EN is defined
module sample_tick_fifo_sink #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [WIDTH-1:0]           in_sample,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_sample,
  output logic                       out_valid,
  output logic                       underrun,
  input  logic                       underrun_clr,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef SAMPLE_FIFO_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]                underrun_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic push;
  logic pop;
  logic urun_evt;

  // Handshake and event decode; no bypass from write side to a same-cycle tick.
  always_comb begin
    in_ready = (count != CNT_W'(DEPTH));
    push     = in_valid && in_ready;
    pop      = tick && (count != '0);
    urun_evt = tick && (count == '0);
  end

  assign level = count;

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_sample;
    end
  end

  // Pointers, occupancy, output register and sticky underrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      // Every tick strobes out_valid so the DAC keeps cadence; an underrun
      // leaves out_sample untouched (hold-last-sample).
      out_valid <= tick;
      if (pop) begin
        out_sample <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      // Set has priority over clear.
      if (urun_evt) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

`ifdef SAMPLE_FIFO_UNDERRUN_COUNT_EN
  // Saturating event counter; clear with a concurrent event restarts at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_count <= '0;
    end else if (urun_evt) begin
      if (underrun_clr) begin
        underrun_count <= 16'd1;
      end else if (underrun_count != 16'hFFFF) begin
        underrun_count <= underrun_count + 16'd1;
      end
    end else if (underrun_clr) begin
      underrun_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sample_tick_fifo_sink.sv
// Directed testbench for sample_tick_fifo_sink (WIDTH=16, DEPTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sample_tick_fifo_sink;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [15:0] in_sample;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        underrun;
  logic        underrun_clr;
  logic [3:0]  level;
`ifdef SAMPLE_FIFO_UNDERRUN_COUNT_EN
  logic [15:0] underrun_count;
`endif

  int vecs = 0;
  int errs = 0;

  sample_tick_fifo_sink #(.WIDTH(16), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .in_sample    (in_sample),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .level        (level)
`ifdef SAMPLE_FIFO_UNDERRUN_COUNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs; returns after the following falling edge.
  task automatic drive(input logic v, input logic [15:0] s, input logic t, input logic c);
    in_valid     = v;
    in_sample    = s;
    tick         = t;
    underrun_clr = c;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'hAAAA, 1'b1, 1'b0);
    drive(1'b1, 16'hAAAA, 1'b1, 1'b0);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (out_sample !== 16'h0000) begin errs++; $display("FAIL reset_out_sample got %h want 0000", out_sample); end
    vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL reset_underrun got %b want 0", underrun); end
    vecs++; if (level !== 4'd0) begin errs++; $display("FAIL reset_level got %0d want 0", level); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL first_tick_valid got %b want 1", out_valid); end
    vecs++; if (out_sample !== 16'h0000) begin errs++; $display("FAIL first_tick_sample got %h want 0000", out_sample); end
    vecs++; if (underrun !== 1'b1) begin errs++; $display("FAIL first_tick_underrun got %b want 1", underrun); end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL clr_underrun got %b want 0", underrun); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL idle_valid got %b want 0", out_valid); end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0);
      vecs++; if (level !== 4'(i)) begin errs++; $display("FAIL fill_level[%0d] got %0d want %0d", i, level, i); end
    end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    drive(1'b1, 16'h0009, 1'b0, 1'b0);
    vecs++; if (level !== 4'd8) begin errs++; $display("FAIL refused_push_level got %0d want 8", level); end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL drain_valid[%0d] got %b want 1", i, out_valid); end
      vecs++; if (out_sample !== 16'(i)) begin errs++; $display("FAIL drain_sample[%0d] got %h want %h", i, out_sample, 16'(i)); end
      vecs++; if (level !== 4'(8 - i)) begin errs++; $display("FAIL drain_level[%0d] got %0d want %0d", i, level, 8 - i); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL drain_in_ready[%0d] got %b want 1", i, in_ready); end
    end
    vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL drain_no_underrun got %b want 0", underrun); end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL post_drain_valid got %b want 0", out_valid); end
    vecs++; if (out_sample !== 16'h0008) begin errs++; $display("FAIL post_drain_hold got %h want 0008", out_sample); end
  endtask

  task automatic test_underrun_hold();
    drive(1'b1, 16'h7FFF, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    vecs++; if (out_sample !== 16'h7FFF) begin errs++; $display("FAIL hold_first got %h want 7fff", out_sample); end
    vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL hold_first_underrun got %b want 0", underrun); end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    vecs++; if (out_sample !== 16'h7FFF) begin errs++; $display("FAIL hold_second got %h want 7fff", out_sample); end
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL hold_second_valid got %b want 1", out_valid); end
    vecs++; if (underrun !== 1'b1) begin errs++; $display("FAIL hold_second_underrun got %b want 1", underrun); end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL hold_clr got %b want 0", underrun); end
    // Clear concurrent with a new underrun: set wins.
    drive(1'b0, 16'h0000, 1'b1, 1'b1);
    vecs++; if (underrun !== 1'b1) begin errs++; $display("FAIL set_wins got %b want 1", underrun); end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL set_wins_clr got %b want 0", underrun); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 16'hA001, 1'b0, 1'b0);
    drive(1'b1, 16'hA002, 1'b0, 1'b0);
    drive(1'b1, 16'hA003, 1'b0, 1'b0);
    drive(1'b1, 16'hA004, 1'b1, 1'b0);
    vecs++; if (level !== 4'd3) begin errs++; $display("FAIL simul_level got %0d want 3", level); end
    vecs++; if (out_sample !== 16'hA001) begin errs++; $display("FAIL simul_sample got %h want a001", out_sample); end
    for (int i = 2; i <= 4; i++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      vecs++; if (out_sample !== 16'hA000 + 16'(i)) begin errs++; $display("FAIL simul_order[%0d] got %h want %h", i, out_sample, 16'hA000 + 16'(i)); end
    end
    vecs++; if (level !== 4'd0) begin errs++; $display("FAIL simul_empty got %0d want 0", level); end
    // Empty FIFO: push and tick together is an underrun; no bypass.
    drive(1'b1, 16'hB005, 1'b1, 1'b0);
    vecs++; if (underrun !== 1'b1) begin errs++; $display("FAIL nobypass_underrun got %b want 1", underrun); end
    vecs++; if (level !== 4'd1) begin errs++; $display("FAIL nobypass_level got %0d want 1", level); end
    vecs++; if (out_sample !== 16'hA004) begin errs++; $display("FAIL nobypass_hold got %h want a004", out_sample); end
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL nobypass_valid got %b want 1", out_valid); end
    drive(1'b0, 16'h0000, 1'b1, 1'b1);
    vecs++; if (out_sample !== 16'hB005) begin errs++; $display("FAIL nobypass_next got %h want b005", out_sample); end
    vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL nobypass_clr got %b want 0", underrun); end
    vecs++; if (level !== 4'd0) begin errs++; $display("FAIL nobypass_drained got %0d want 0", level); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 16'hC000, 1'b0, 1'b0);
    drive(1'b1, 16'hC001, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'hC002 + 16'(i), 1'b1, 1'b0);
      vecs++; if (out_sample !== 16'hC000 + 16'(i)) begin errs++; $display("FAIL wrap_sample[%0d] got %h want %h", i, out_sample, 16'hC000 + 16'(i)); end
      vecs++; if (level !== 4'd2) begin errs++; $display("FAIL wrap_level[%0d] got %0d want 2", i, level); end
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    vecs++; if (out_sample !== 16'hC014) begin errs++; $display("FAIL wrap_tail0 got %h want c014", out_sample); end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    vecs++; if (out_sample !== 16'hC015) begin errs++; $display("FAIL wrap_tail1 got %h want c015", out_sample); end
    vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL wrap_no_underrun got %b want 0", underrun); end
    vecs++; if (level !== 4'd0) begin errs++; $display("FAIL wrap_end_level got %0d want 0", level); end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

`ifdef SAMPLE_FIFO_UNDERRUN_COUNT_EN
  task automatic test_underrun_count();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    vecs++; if (underrun_count !== 16'd0) begin errs++; $display("FAIL ucnt_clear got %0d want 0", underrun_count); end
    for (int i = 0; i < 5; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
    vecs++; if (underrun_count !== 16'd5) begin errs++; $display("FAIL ucnt_five got %0d want 5", underrun_count); end
    drive(1'b0, 16'h0000, 1'b1, 1'b1);
    vecs++; if (underrun_count !== 16'd1) begin errs++; $display("FAIL ucnt_clr_evt got %0d want 1", underrun_count); end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    vecs++; if (underrun_count !== 16'd0) begin errs++; $display("FAIL ucnt_clr got %0d want 0", underrun_count); end
  endtask
`endif

  task automatic test_reset_mid_operation();
    drive(1'b1, 16'hD001, 1'b0, 1'b0);
    drive(1'b1, 16'hD002, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    vecs++; if (level !== 4'd0) begin errs++; $display("FAIL midrst_level got %0d want 0", level); end
    drive(1'b1, 16'hE001, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    vecs++; if (out_sample !== 16'hE001) begin errs++; $display("FAIL midrst_sample got %h want e001", out_sample); end
    vecs++; if (underrun !== 1'b0) begin errs++; $display("FAIL midrst_underrun got %b want 0", underrun); end
  endtask

  initial begin
    rst          = 1'b1;
    tick         = 1'b0;
    in_valid     = 1'b0;
    in_sample    = '0;
    underrun_clr = 1'b0;
    test_reset();
    test_fill_drain();
    test_underrun_hold();
    test_simultaneous();
    test_wrap();
`ifdef SAMPLE_FIFO_UNDERRUN_COUNT_EN
    test_underrun_count();
`endif
    test_reset_mid_operation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
